// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, programmable almost flags,
// sticky overflow/underflow, synchronous clear and optional first-word-fall-through.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_full,
  output logic              w_almost_full,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_empty,
  output logic              r_almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              w_full_q, w_full_d;
  logic              w_af_q, w_af_d;
  logic              r_empty_q, r_empty_d;
  logic              r_ae_q, r_ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;

  // Next-state: acceptance uses the flags registered before this edge.
  always_comb begin
    wr_acc   = w_en & ~w_full_q;
    rd_acc   = r_en & ~r_empty_q;
    mem_we   = 1'b0;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    r_data_d = r_data_q;

    if (clr) begin
      wptr_d  = ZERO_C;
      rptr_d  = ZERO_C;
      count_d = ZERO_C;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      mem_we = wr_acc;
      ovf_d  = ovf_q | (w_en & w_full_q);
      unf_d  = unf_q | (r_en & r_empty_q);
      if (wr_acc) begin
        wptr_d = wptr_q + ONE_C;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc) begin
        rptr_d   = rptr_q + ONE_C;
        r_data_d = mem_q[rptr_q[ADDR_W-1:0]];
      end else begin
        rptr_d   = rptr_q;
        r_data_d = r_data_q;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end

    w_full_d  = (count_d == DEPTH_C);
    r_empty_d = (count_d == ZERO_C);
    w_af_d    = (count_d >= AF_C);
    r_ae_d    = (count_d <= AE_C);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= ZERO_C;
      rptr_q    <= ZERO_C;
      count_q   <= ZERO_C;
      w_full_q  <= 1'b0;
      w_af_q    <= 1'b0;
      r_empty_q <= 1'b1;
      r_ae_q    <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      r_data_q  <= {DATA_W{1'b0}};
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      w_full_q  <= w_full_d;
      w_af_q    <= w_af_d;
      r_empty_q <= r_empty_d;
      r_ae_q    <= r_ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      r_data_q  <= r_data_d;
    end
  end

  // Storage array; contents are left untouched by reset and clear.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= w_data;
    end else begin
      mem_q[wptr_q[ADDR_W-1:0]] <= mem_q[wptr_q[ADDR_W-1:0]];
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign r_data = mem_q[rptr_q[ADDR_W-1:0]];
    end else begin : g_std
      assign r_data = r_data_q;
    end
  endgenerate

  assign w_full         = w_full_q;
  assign w_almost_full  = w_af_q;
  assign r_empty        = r_empty_q;
  assign r_almost_empty = r_ae_q;
  assign count          = count_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// compares both against a queue-based reference model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n, clr, w_en, r_en;
  logic [7:0] w_data;

  logic       s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
  logic [7:0] s_rdata;
  logic [4:0] s_count;
  logic       f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
  logic [7:0] f_rdata;
  logic [4:0] f_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] std_exp;
  logic       ovf_m, unf_m;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .w_data(w_data),
    .w_full(s_full), .w_almost_full(s_af), .r_en(r_en), .r_data(s_rdata),
    .r_empty(s_empty), .r_almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .w_data(w_data),
    .w_full(f_full), .w_almost_full(f_af), .r_en(r_en), .r_data(f_rdata),
    .r_empty(f_empty), .r_almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_count", s_count, n);
    chk("s_full",  s_full,  (n == 16));
    chk("s_af",    s_af,    (n >= 14));
    chk("s_empty", s_empty, (n == 0));
    chk("s_ae",    s_ae,    (n <= 2));
    chk("s_ovf",   s_ovf,   ovf_m);
    chk("s_unf",   s_unf,   unf_m);
    chk("s_rdata", s_rdata, std_exp);
    chk("f_count", f_count, n);
    chk("f_full",  f_full,  (n == 16));
    chk("f_af",    f_af,    (n >= 14));
    chk("f_empty", f_empty, (n == 0));
    chk("f_ae",    f_ae,    (n <= 2));
    chk("f_ovf",   f_ovf,   ovf_m);
    chk("f_unf",   f_unf,   unf_m);
    if (n > 0) chk("f_rdata", f_rdata, q[0]);
  endtask

  // One clock: apply inputs, advance the model at the edge, compare just after it.
  task automatic cyc(input logic rn, input logic c, input logic w, input logic r,
                     input logic [7:0] d);
    bit full, empty;
    rst_n = rn; clr = c; w_en = w; r_en = r; w_data = d;
    @(posedge clk);
    if (!rn) begin
      q.delete(); ovf_m = 1'b0; unf_m = 1'b0; std_exp = 8'h00;
    end else if (c) begin
      q.delete(); ovf_m = 1'b0; unf_m = 1'b0;
    end else begin
      full  = (q.size() == 16);
      empty = (q.size() == 0);
      if (w && full)  ovf_m = 1'b1;
      if (r && empty) unf_m = 1'b1;
      if (r && !empty) std_exp = q.pop_front();
      if (w && !full)  q.push_back(d);
    end
    #1;
    check_all();
  endtask

  task automatic wr(input logic [7:0] d);  cyc(1'b1, 1'b0, 1'b1, 1'b0, d); endtask
  task automatic rd();                     cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00); endtask
  task automatic rst();                    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); endtask

  initial begin
    q.delete(); std_exp = 8'h00; ovf_m = 1'b0; unf_m = 1'b0;
    rst_n = 1'b0; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = 8'h00;
    rst(); rst();

    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_cnt", s_count, 5'd16);
    wr(8'hAA);
    chk("ovf_full", s_ovf, 1'b1);

    for (int i = 0; i < 16; i++) rd();
    chk("drain_empty", s_empty, 1'b1);
    rd();
    chk("unf_empty", s_unf, 1'b1);
    chk("hold_rdata", s_rdata, 8'h0F);

    rst();
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'($urandom));
    chk("wrap_cnt", s_count, 5'd8);

    for (int i = 0; i < 8; i++) wr(8'($urandom));
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);
    chk("full_wr_rd_cnt", s_count, 5'd15);

    rst();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h11);
    chk("empty_wr_rd_cnt", s_count, 5'd1);
    chk("empty_wr_rd_unf", s_unf, 1'b1);

    rst();
    wr(8'h5C);
    chk("fwft_first", f_rdata, 8'h5C);
    wr(8'h77);
    rd();
    chk("fwft_next", f_rdata, 8'h77);

    rst();
    for (int i = 0; i < 17; i++) wr(8'($urandom));
    for (int i = 0; i < 7; i++) rd();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
    chk("clr_cnt", s_count, 5'd0);
    chk("clr_ovf", s_ovf, 1'b0);

    for (int i = 0; i < 17; i++) wr(8'($urandom));
    for (int i = 0; i < 7; i++) rd();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE);
    chk("rst_rdata", s_rdata, 8'h00);
    chk("rst_empty", s_empty, 1'b1);

    // Random traffic with a per-segment bias so fill level sweeps the whole range.
    for (int seg = 0; seg < 12; seg++) begin
      int pw, pr;
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO succeeding the team's fixed 8-bit x 256 dual-clock FIFO.
- Used where producer and consumer share one clock domain.
- Adds the following, all selectable by parameter:
  - configurable data width and depth
  - fill count
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - synchronous clear
  - standard or first-word-fall-through (FWFT) read mode

Parameters:
- DATA_W, 8: data width in bits.
- ADDR_W, 8: address width; DEPTH = 2^ADDR_W entries.
- AF_LEVEL, 2^ADDR_W-2: w_almost_full asserts when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2: r_almost_empty asserts when count <= AE_LEVEL. Legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clr  in  1  synchronous flush; active high.
- w_en  in  1  write request.
- w_data  in  DATA_W  write data.
- w_full  out  1  FIFO holds DEPTH words.
- w_almost_full  out  1  count >= AF_LEVEL.
- r_en  in  1  read request.
- r_data  out  DATA_W  read data.
- r_empty  out  1  FIFO holds 0 words.
- r_almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current number of stored words, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset values (rst_n=0 at an edge):
  - write and read pointers (ADDR_W+1 bits each) = 0; count = 0
  - r_empty = 1, r_almost_empty = 1, w_full = 0, w_almost_full = 0
  - overflow = 0, underflow = 0, r_data = 0
  - Reset overrides every other input. Reset mid-operation discards all contents.
- Priority: rst_n, then clr, then w_en/r_en.
- clr=1 at an edge:
  - pointers, count and sticky flags return to their reset values.
  - Memory contents and r_data (standard mode) are not required to change.
  - Simultaneous w_en/r_en in that cycle are ignored and do not set the sticky flags.
- Write/read acceptance:
  - Write accepted when w_en & !w_full; read accepted when r_en & !r_empty.
  - Both are evaluated on the flag values present before the edge.
  - Accepted write stores w_data at mem[wptr[ADDR_W-1:0]]; wptr increments.
  - Accepted read increments rptr. Pointers wrap naturally modulo 2*DEPTH.
- Count and flags:
  - count_next = count + wr_acc - rd_acc.
  - Flags are functions of the registered count only:
    - w_full = (count == DEPTH)
    - r_empty = (count == 0)
    - w_almost_full = (count >= AF_LEVEL)
    - r_almost_empty = (count <= AE_LEVEL)
  - A write into an empty FIFO clears r_empty in the cycle following the write edge.
- Simultaneous w_en & r_en:
  - Not empty and not full: both accepted, count unchanged, works across pointer wrap.
  - Full: read only accepted; count goes DEPTH -> DEPTH-1; overflow sets.
  - Empty: write only accepted; count goes 0 -> 1; underflow sets.
- Standard mode (FWFT=0):
  - r_data is registered and loads mem[rptr] at the edge where the read is accepted.
  - Read latency is 1 cycle: data is valid after that edge.
  - r_data holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - r_data = mem[rptr] continuously; it is valid whenever r_empty=0.
  - An accepted read advances to the next word, visible after the edge.
  - r_data is don't-care while r_empty=1.
- Sticky flags:
  - overflow sets at any edge with w_en & w_full.
  - underflow sets at any edge with r_en & r_empty.
  - Both stay set until rst_n or clr. The refused transfer has no other effect.

Test Plan (DATA_W=8, ADDR_W=4, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2):
- Reset, then write 0x00..0x0F on consecutive cycles:
  - count steps 1..16; r_almost_empty drops when count=3; w_almost_full rises when count=14; w_full rises when count=16.
  - Then write 0xAA -> refused, count stays 16, overflow=1.
- Full FIFO, FWFT=0, read 16 times:
  - r_data = 0x00..0x0F, each one cycle after its read edge; r_empty=1 after the 16th read.
  - Extra read -> underflow=1, r_data holds 0x0F.
- Count at 8, w_en=r_en=1 for 40 cycles (pointers wrap):
  - count stays 8; output sequence equals input sequence with no loss.
- Full FIFO, w_en=r_en=1 -> count=15, overflow=1. Empty FIFO, w_en=r_en=1 -> count=1, underflow=1.
- FWFT=1: write 0x5C into empty FIFO:
  - next cycle r_empty=0 and r_data=0x5C with no r_en.
  - Read with 0x77 queued -> r_data=0x77 after the edge.
- Count at 9, overflow=1; assert clr with w_en=1 -> count=0, r_empty=1, overflow=0. Repeat with rst_n=0 mid-burst -> same result plus r_data=0.
